amult_pipe: RTL and testbench

- Pipelined, handshaked successor to the combinational approximate shift-add multiplier used in the softmax datapath.
- Multiplies signed DAT_IN by an unsigned fractional coefficient SHIFT_VAL (0.SHIFT_VAL, MSB weight 2^-1) as a sum of arithmetic right-shifts.
- Generalised in coefficient width, adder grouping and rounding mode.
- Adds valid/ready flow control with backpressure and a sideband tag, so it can sit between softmax stages that stall independently.

---
 rtl/amult_if.sv | 24 ++
 rtl/amult_pipe.sv | 72 +++++++
 tb/tb_amult_pipe.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/amult_if.sv
// amult_if: valid/ready upstream and downstream bundle for amult_pipe.
interface amult_if #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dat_in;
    logic [SHIFT-1:0] shift_val;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dat_out;
    logic [TAG_W-1:0] out_tag;
    modport master (
        output in_valid, dat_in, shift_val, in_tag, out_ready,
        input  in_ready, out_valid, dat_out, out_tag
    );
    modport slave (
        input  in_valid, dat_in, shift_val, in_tag, out_ready,
        output in_ready, out_valid, dat_out, out_tag
    );
endinterface

// File: rtl/amult_pipe.sv
// amult_pipe: 3-stage handshaked approximate multiplier, DAT_IN * 0.SHIFT_VAL as a sum of
// arithmetic right-shifts, with per-stage valid bits so empty stages fill under backpressure.
module amult_pipe #(
    parameter int WIDTH      = 32,
    parameter int SHIFT      = 16,
    parameter int GROUP      = 4,
    parameter int ROUND_MODE = 0,
    parameter int TAG_W      = 4
) (
    input logic    clk,
    input logic    rst_n,
    amult_if.slave bus
);
    localparam int NGROUP = (SHIFT + GROUP - 1) / GROUP;
    logic             v1_q, v2_q, v3_q;
    logic             r1, r2, r3;
    logic [WIDTH-1:0] dat1_q;
    logic [SHIFT-1:0] sv1_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
    logic [WIDTH-1:0] term [SHIFT];
    logic [WIDTH-1:0] grp_d [NGROUP];
    logic [WIDTH-1:0] grp_q [NGROUP];
    logic [WIDTH-1:0] sum_d, dat3_q;
    assign r3 = !v3_q || bus.out_ready;
    assign r2 = !v2_q || r3;
    assign r1 = !v1_q || r2;
    assign bus.in_ready  = r1;
    assign bus.out_valid = v3_q;
    assign bus.dat_out   = dat3_q;
    assign bus.out_tag   = tag3_q;
    // One extra bit keeps the rounding offset from overflowing before the shift.
    for (genvar i = 0; i < SHIFT; i++) begin : g_term
        localparam logic [WIDTH:0] HALF = ROUND_MODE != 0 ? (WIDTH+1)'(1) << i : '0;
        logic signed [WIDTH:0] ext;
        assign ext     = {dat1_q[WIDTH-1], dat1_q} + HALF;
        assign term[i] = sv1_q[SHIFT-1-i] ? WIDTH'(ext >>> (i + 1)) : '0;
    end
    always_comb begin
        for (int g = 0; g < NGROUP; g++) grp_d[g] = '0;
        for (int i = 0; i < SHIFT; i++) grp_d[i/GROUP] = grp_d[i/GROUP] + term[i];
        sum_d = '0;
        for (int g = 0; g < NGROUP; g++) sum_d = sum_d + grp_q[g];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            dat3_q <= '0;
            tag3_q <= '0;
        end else begin
            if (r1) v1_q <= bus.in_valid;
            if (r2) v2_q <= v1_q;
            if (r3) v3_q <= v2_q;
            if (r3 && v2_q) begin
                dat3_q <= sum_d;
                tag3_q <= tag2_q;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (r1 && bus.in_valid) begin
            dat1_q <= bus.dat_in;
            sv1_q  <= bus.shift_val;
            tag1_q <= bus.in_tag;
        end
        if (r2 && v1_q) begin
            grp_q  <= grp_d;
            tag2_q <= tag1_q;
        end
    end
endmodule

// File: tb/tb_amult_pipe.sv
// tb_amult_pipe: randomized and directed checks of amult_pipe against an arithmetic reference
// model; a second bank of instances sweeps coefficient width, grouping and rounding.
module tb_amult_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;

    amult_if #(.WIDTH(32), .SHIFT(16), .TAG_W(4)) m_if ();
    amult_pipe dut (.clk(clk), .rst_n(rst_n), .bus(m_if));

    localparam int NC = 5;
    localparam logic [NC-1:0][7:0] SHP = {8'd12, 8'd12, 8'd8, 8'd8, 8'd16};
    localparam logic [NC-1:0][7:0] GRP = {8'd5, 8'd5, 8'd3, 8'd3, 8'd4};
    localparam logic [NC-1:0][7:0] RMP = {8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
    logic        s_valid;
    logic [31:0] s_dat;
    logic [15:0] s_sv;
    logic [31:0] s_out [NC];
    logic [3:0]  s_tag [NC];
    logic        s_ov  [NC];
    logic        s_rdy [NC];
    for (genvar c = 0; c < NC; c++) begin : g_cfg
        amult_if #(.WIDTH(32), .SHIFT(int'(SHP[c])), .TAG_W(4)) sif ();
        assign sif.in_valid  = s_valid;
        assign sif.dat_in    = s_dat;
        assign sif.shift_val = s_sv[int'(SHP[c])-1:0];
        assign sif.in_tag    = 4'(c);
        assign sif.out_ready = 1'b1;
        assign s_out[c] = sif.dat_out;
        assign s_tag[c] = sif.out_tag;
        assign s_ov[c]  = sif.out_valid;
        assign s_rdy[c] = sif.in_ready;
        amult_pipe #(.SHIFT(int'(SHP[c])), .GROUP(int'(GRP[c])), .ROUND_MODE(int'(RMP[c])))
            dut_s (.clk(clk), .rst_n(rst_n), .bus(sif));
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Each selected term is floor(x / 2^k), or floor((x + 2^(k-1)) / 2^k) when rounding.
    function automatic logic [31:0] ref_mul(input logic [31:0] d, input logic [15:0] sv,
                                            input int sh, input int rm);
        longint x, acc, num, p, q;
        x   = longint'($signed(d));
        acc = 0;
        for (int i = 0; i < sh; i++) begin
            if (sv[sh-1-i]) begin
                p   = longint'(1) << (i + 1);
                num = x + (rm != 0 ? p / 2 : 0);
                q   = num / p;
                if (num % p != 0 && num < 0) q = q - 1;
                acc = acc + q;
            end
        end
        return acc[31:0];
    endfunction

    task automatic one_beat(input logic [31:0] d, input logic [15:0] sv, input logic [3:0] tg,
                            input logic [31:0] exp, input string nm);
        @(negedge clk);
        m_if.in_valid  = 1'b1;
        m_if.dat_in    = d;
        m_if.shift_val = sv;
        m_if.in_tag    = tg;
        m_if.out_ready = 1'b1;
        @(negedge clk);
        m_if.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_early"}, 64'(m_if.out_valid), 64'(0));
        @(negedge clk);
        chk({nm, "_valid"}, 64'(m_if.out_valid), 64'(1));
        chk({nm, "_dat"}, 64'(m_if.dat_out), 64'(exp));
        chk({nm, "_tag"}, 64'(m_if.out_tag), 64'(tg));
        @(negedge clk);
        chk({nm, "_once"}, 64'(m_if.out_valid), 64'(0));
    endtask

    task automatic sweep_beat(input logic [31:0] d, input logic [15:0] sv);
        @(negedge clk);
        for (int c = 0; c < NC; c++) chk("sweep_rdy", 64'(s_rdy[c]), 64'(1));
        s_valid = 1'b1;
        s_dat   = d;
        s_sv    = sv;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            chk("sweep_valid", 64'(s_ov[c]), 64'(1));
            chk("sweep_tag", 64'(s_tag[c]), 64'(c));
            chk("sweep_dat", 64'(s_out[c]), 64'(ref_mul(d, sv, int'(SHP[c]), int'(RMP[c]))));
        end
    endtask

    task automatic stream(input int n, input bit rnd, output int cyc);
        logic [35:0] q[$];
        logic [35:0] held;
        bit          stall, taken;
        int          occ, n_in, n_out;
        stall = 0; taken = 0; occ = 0; n_in = 0; n_out = 0; cyc = 0; held = '0;
        while (n_out < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                chk("hold_valid", 64'(m_if.out_valid), 64'(1));
                chk("hold_data", 64'({m_if.out_tag, m_if.dat_out}), 64'(held));
            end
            m_if.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (taken) m_if.in_valid = 1'b0;
            taken = 0;
            if (!m_if.in_valid && n_in < n) begin
                m_if.dat_in    = $urandom;
                m_if.shift_val = 16'($urandom);
                m_if.in_tag    = 4'(n_in);
                m_if.in_valid  = 1'b1;
            end
            #1;
            chk("in_ready", 64'(m_if.in_ready), 64'(!(occ == 3 && !m_if.out_ready)));
            if (m_if.out_valid) begin
                if (q.size() == 0) chk("spurious_out", 64'(1), 64'(0));
                else chk("stream_out", 64'({m_if.out_tag, m_if.dat_out}), 64'(q[0]));
            end
            stall = m_if.out_valid && !m_if.out_ready;
            held  = {m_if.out_tag, m_if.dat_out};
            if (m_if.out_valid && m_if.out_ready) begin
                if (q.size() != 0) void'(q.pop_front());
                n_out++;
                occ--;
            end
            if (m_if.in_valid && m_if.in_ready) begin
                q.push_back({m_if.in_tag, ref_mul(m_if.dat_in, m_if.shift_val, 16, 0)});
                n_in++;
                occ++;
                taken = 1;
            end
        end
        m_if.in_valid = 1'b0;
        chk("stream_count", 64'(n_out), 64'(n));
    endtask

    initial begin
        int cyc;
        int stale;
        m_if.in_valid = 0; m_if.dat_in = 0; m_if.shift_val = 0; m_if.in_tag = 0;
        m_if.out_ready = 1;
        s_valid = 0; s_dat = 0; s_sv = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(m_if.out_valid), 64'(0));
        chk("rst_dat", 64'(m_if.dat_out), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(m_if.in_ready), 64'(1));
        chk("rst_tag", 64'(m_if.out_tag), 64'(0));
        one_beat(32'h00010000, 16'h8000, 4'h3, 32'h00008000, "half");
        one_beat(32'h00010000, 16'hFFFF, 4'h5, 32'h0000FFFF, "all_ones");
        one_beat(32'hFFFFFFFD, 16'h8000, 4'h9, 32'hFFFFFFFE, "neg_trunc");
        one_beat(32'h00000003, 16'h8000, 4'hA, 32'h00000001, "pos_trunc");
        one_beat(32'h12345678, 16'h0000, 4'hF, 32'h00000000, "zero_coef");
        sweep_beat(32'h00000003, 16'h8000);
        chk("rm1_pos", 64'(s_out[0]), 64'(32'h00000002));
        sweep_beat(32'hFFFFFFFD, 16'h8000);
        chk("rm1_neg", 64'(s_out[0]), 64'(32'hFFFFFFFF));
        repeat (40) sweep_beat($urandom, 16'($urandom));
        stream(8, 1'b1, cyc);
        stream(10, 1'b0, cyc);
        chk("rate_cycles", 64'(cyc), 64'(13));
        @(negedge clk);
        m_if.out_ready = 1'b0;
        m_if.in_valid  = 1'b1;
        m_if.dat_in    = 32'h00010000;
        m_if.shift_val = 16'h8000;
        for (int i = 0; i < 3; i++) begin
            m_if.in_tag = 4'(8 + i);
            #1 chk("fill_ready", 64'(m_if.in_ready), 64'(1));
            @(negedge clk);
        end
        m_if.in_valid = 1'b0;
        chk("full_ready", 64'(m_if.in_ready), 64'(0));
        chk("full_valid", 64'(m_if.out_valid), 64'(1));
        chk("full_dat", 64'(m_if.dat_out), 64'(32'h00008000));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(m_if.out_valid), 64'(0));
        chk("mid_rst_dat", 64'(m_if.dat_out), 64'(0));
        chk("mid_rst_tag", 64'(m_if.out_tag), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_if.out_ready = 1'b1;
        #1 chk("post_rst_ready", 64'(m_if.in_ready), 64'(1));
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_if.out_valid) stale++;
        end
        chk("no_stale", 64'(stale), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
